// File: rtl/cmos_lvds_tx.sv
// cmos_lvds_tx: serialises 10-bit words on four data lanes plus one sync lane,
// two bits per clock ({rise,fall} for ODDR2 D0/D1), MSB first, with full
// frame/line framing on the sync lane.
// Optional build macro: CMOS_TX_TEST_PATTERN_EN enables the internal ramp
// pattern selected by test_mode; without it test_mode is ignored.
module cmos_lvds_tx #(
    parameter int unsigned      PIX_W       = 10,
    parameter int unsigned      LINE_WORDS  = 16,
    parameter int unsigned      FRAME_LINES = 4,
    parameter int unsigned      LINE_GAP    = 2,
    parameter logic [PIX_W-1:0] TRAIN_WORD  = 10'h3A6,
    parameter logic [PIX_W-1:0] FS_CODE     = 10'h2AA,
    parameter logic [PIX_W-1:0] FE_CODE     = 10'h3AA,
    parameter logic [PIX_W-1:0] LS_CODE     = 10'h0AA,
    parameter logic [PIX_W-1:0] LE_CODE     = 10'h1AA,
    parameter logic [PIX_W-1:0] DV_CODE     = 10'h035
) (
    input  logic               clk_input,
    input  logic               rst_n,
    input  logic               start_frame,
    input  logic [4*PIX_W-1:0] pix_data,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [1:0]         lane0_bits,
    output logic [1:0]         lane1_bits,
    output logic [1:0]         lane2_bits,
    output logic [1:0]         lane3_bits,
    output logic [1:0]         sync_bits,
    output logic               busy,
    output logic               frame_done,
    output logic               underrun,
    input  logic               test_mode
);

    localparam int unsigned Half  = PIX_W / 2;
    localparam int unsigned SlotW = (Half > 1) ? $clog2(Half) : 1;
    localparam int unsigned WordW = $clog2(LINE_WORDS + 1);
    localparam int unsigned LineW = $clog2(FRAME_LINES + 1);
    localparam int unsigned GapW  = (LINE_GAP > 0) ? $clog2(LINE_GAP + 1) : 1;

    localparam logic [SlotW-1:0] SlotLast = SlotW'(Half - 1);
    localparam logic [WordW-1:0] WordMax  = WordW'(LINE_WORDS);
    localparam logic [LineW-1:0] LineMax  = LineW'(FRAME_LINES);
    localparam logic [GapW-1:0]  GapMax   = GapW'(LINE_GAP);

    // State names the word type currently on the wire; it advances in the
    // last slot, when the following word is decided and staged.
    typedef enum logic [2:0] {
        StIdle,
        StFs,
        StLs,
        StData,
        StLe,
        StGap,
        StFe
    } state_e;

    state_e                    state_q, state_d;
    logic [SlotW-1:0]          slot_q;
    logic [WordW-1:0]          word_cnt_q, word_cnt_d;
    logic [LineW-1:0]          line_cnt_q, line_cnt_d;
    logic [GapW-1:0]           gap_cnt_q, gap_cnt_d;
    logic                      underrun_q, underrun_d;
    logic [PIX_W-1:0]          sync_nxt_q, sync_nxt_d;
    logic [3:0][PIX_W-1:0]     data_nxt_q, data_nxt_d;
    logic [PIX_W-1:0]          sync_sr_q;
    logic [3:0][PIX_W-1:0]     data_sr_q;
    logic [1:0]                sync_bits_q;
    logic [3:0][1:0]           lane_bits_q;
    logic                      busy_q;
    logic                      frame_done_q;
    logic                      last_slot;

`ifdef CMOS_TX_TEST_PATTERN_EN
    logic                      tp_q, tp_d;
    logic [PIX_W-1:0]          ramp_q, ramp_d;
`else
    logic                      unused_test_mode;
    assign unused_test_mode = test_mode;
`endif

    function automatic logic [PIX_W-1:0] sync_code(input state_e st);
        unique case (st)
            StFs:    sync_code = FS_CODE;
            StLs:    sync_code = LS_CODE;
            StData:  sync_code = DV_CODE;
            StLe:    sync_code = LE_CODE;
            StFe:    sync_code = FE_CODE;
            default: sync_code = TRAIN_WORD;
        endcase
    endfunction

    assign last_slot = (slot_q == SlotLast);

    // Next-word decision: FSM step, counters, handshake and staged word set.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        line_cnt_d = line_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        underrun_d = underrun_q;
        sync_nxt_d = sync_nxt_q;
        data_nxt_d = data_nxt_q;
        pix_ready  = 1'b0;
`ifdef CMOS_TX_TEST_PATTERN_EN
        tp_d       = tp_q;
        ramp_d     = ramp_q;
`endif
        if (last_slot) begin
            unique case (state_q)
                StIdle: begin
                    if (start_frame) begin
                        state_d    = StFs;
                        word_cnt_d = '0;
                        line_cnt_d = '0;
                        underrun_d = 1'b0;
`ifdef CMOS_TX_TEST_PATTERN_EN
                        tp_d       = test_mode;
                        ramp_d     = '0;
`endif
                    end
                end
                StFs: state_d = StLs;
                StLs: begin
                    state_d    = StData;
                    word_cnt_d = WordW'(1);
                end
                StData: begin
                    if (word_cnt_q == WordMax) begin
                        state_d    = StLe;
                        word_cnt_d = '0;
                        line_cnt_d = line_cnt_q + LineW'(1);
                    end else begin
                        word_cnt_d = word_cnt_q + WordW'(1);
                    end
                end
                StLe: begin
                    if (line_cnt_q == LineMax) begin
                        state_d = StFe;
                    end else if (LINE_GAP > 0) begin
                        state_d   = StGap;
                        gap_cnt_d = GapW'(1);
                    end else begin
                        state_d = StLs;
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapMax) begin
                        state_d   = StLs;
                        gap_cnt_d = '0;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GapW'(1);
                    end
                end
                StFe:    state_d = StIdle;
                default: state_d = StIdle;
            endcase

            sync_nxt_d = sync_code(state_d);
            data_nxt_d = {4{TRAIN_WORD}};
            if (state_d == StData) begin
`ifdef CMOS_TX_TEST_PATTERN_EN
                if (tp_q) begin
                    for (int k = 0; k < 4; k++) begin
                        data_nxt_d[k] = ramp_q + PIX_W'(k);
                    end
                    ramp_d = ramp_q + PIX_W'(1);
                end else begin
`endif
                    pix_ready = 1'b1;
                    if (pix_valid) begin
                        data_nxt_d = pix_data;
                    end else begin
                        // Missing pixel: send zeros, keep the line length intact.
                        data_nxt_d = '0;
                        underrun_d = 1'b1;
                    end
`ifdef CMOS_TX_TEST_PATTERN_EN
                end
`endif
            end
        end
    end

    // Slot counter, FSM, counters and the staged next-word registers.
    always_ff @(posedge clk_input) begin
        if (!rst_n) begin
            slot_q     <= '0;
            state_q    <= StIdle;
            word_cnt_q <= '0;
            line_cnt_q <= '0;
            gap_cnt_q  <= '0;
            underrun_q <= 1'b0;
            sync_nxt_q <= TRAIN_WORD;
            data_nxt_q <= {4{TRAIN_WORD}};
`ifdef CMOS_TX_TEST_PATTERN_EN
            tp_q       <= 1'b0;
            ramp_q     <= '0;
`endif
        end else begin
            slot_q     <= last_slot ? '0 : slot_q + SlotW'(1);
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            line_cnt_q <= line_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            underrun_q <= underrun_d;
            sync_nxt_q <= sync_nxt_d;
            data_nxt_q <= data_nxt_d;
`ifdef CMOS_TX_TEST_PATTERN_EN
            tp_q       <= tp_d;
            ramp_q     <= ramp_d;
`endif
        end
    end

    // Shifters and bit-pair outputs; slot 0 loads the staged word set while
    // the previous word's last pair goes out.
    always_ff @(posedge clk_input) begin
        if (!rst_n) begin
            sync_sr_q    <= '0;
            data_sr_q    <= '0;
            sync_bits_q  <= 2'b00;
            lane_bits_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sync_bits_q <= sync_sr_q[PIX_W-1 -: 2];
            for (int k = 0; k < 4; k++) begin
                lane_bits_q[k] <= data_sr_q[k][PIX_W-1 -: 2];
            end
            frame_done_q <= 1'b0;
            if (slot_q == '0) begin
                sync_sr_q    <= sync_nxt_q;
                data_sr_q    <= data_nxt_q;
                // state_q here is the type of the word being loaded.
                busy_q       <= (state_q != StIdle);
                frame_done_q <= busy_q && (state_q == StIdle);
            end else begin
                sync_sr_q <= sync_sr_q << 2;
                for (int k = 0; k < 4; k++) begin
                    data_sr_q[k] <= data_sr_q[k] << 2;
                end
            end
        end
    end

    assign sync_bits  = sync_bits_q;
    assign lane0_bits = lane_bits_q[0];
    assign lane1_bits = lane_bits_q[1];
    assign lane2_bits = lane_bits_q[2];
    assign lane3_bits = lane_bits_q[3];
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_cmos_lvds_tx.sv
// Directed bench for cmos_lvds_tx: deserialises every lane word by word and
// compares against a hand-built frame table and a table of frame scenarios.
`timescale 1ns/1ps
module tb_cmos_lvds_tx;

    localparam logic [9:0] TRAIN = 10'h3A6;
    localparam logic [9:0] FS    = 10'h2AA;
    localparam logic [9:0] FE    = 10'h3AA;
    localparam logic [9:0] LS    = 10'h0AA;
    localparam logic [9:0] LE    = 10'h1AA;
    localparam logic [9:0] DV    = 10'h035;
`ifdef CMOS_TX_TEST_PATTERN_EN
    localparam bit TpEn = 1'b1;
`else
    localparam bit TpEn = 1'b0;
`endif

    logic        clk_input   = 1'b0;
    logic        rst_n       = 1'b0;
    logic        start_frame = 1'b0;
    logic [39:0] pix_data    = '0;
    logic        pix_valid   = 1'b0;
    logic        test_mode   = 1'b0;
    logic        pix_ready;
    logic [1:0]  lane0_bits, lane1_bits, lane2_bits, lane3_bits, sync_bits;
    logic        busy, frame_done, underrun;

    int checks    = 0;
    int errors    = 0;
    int hs_cnt    = 0;
    int fd_cnt    = 0;
    int ready_idx = 0;
    bit drop_en   = 1'b0;
    logic [9:0] dxor = '0;

    // One expected word of a frame: sync code, data flag, frame data index.
    typedef struct {
        logic [9:0] sync;
        bit         data;
        int         didx;
    } frm_t;

    // One frame scenario: stimulus controls and expected end-of-frame results.
    typedef struct {
        bit         drop;
        bit         hold;
        bit         skip_pre;
        bit         mid;
        bit         tmode;
        logic [9:0] dx;
        int         exp_hs;
        int         exp_rdy;
        bit         exp_urun;
    } cfg_t;

    frm_t frm[80];
    cfg_t cfg[5];

    cmos_lvds_tx dut (
        .clk_input   (clk_input),
        .rst_n       (rst_n),
        .start_frame (start_frame),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .lane0_bits  (lane0_bits),
        .lane1_bits  (lane1_bits),
        .lane2_bits  (lane2_bits),
        .lane3_bits  (lane3_bits),
        .sync_bits   (sync_bits),
        .busy        (busy),
        .frame_done  (frame_done),
        .underrun    (underrun),
        .test_mode   (test_mode)
    );

    always #5 clk_input = ~clk_input;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Collects one word slot (five pairs) from every lane; drives pixel inputs.
    task automatic get_word(output logic [9:0] s, output logic [39:0] l, output logic b);
        logic [3:0][9:0] w;
        s = '0;
        w = '0;
        b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_input);
            s    = {s[7:0], sync_bits};
            w[0] = {w[0][7:0], lane0_bits};
            w[1] = {w[1][7:0], lane1_bits};
            w[2] = {w[2][7:0], lane2_bits};
            w[3] = {w[3][7:0], lane3_bits};
            if (i == 0) b = busy;
            if (frame_done) fd_cnt++;
            for (int k = 0; k < 4; k++) begin
                pix_data[k*10 +: 10] = 10'(ready_idx + k) ^ dxor;
            end
            pix_valid = !(drop_en && ready_idx == 21);
            if (pix_ready) begin
                if (pix_valid) hs_cnt++;
                ready_idx++;
            end
        end
        l = w;
    endtask

    function automatic logic [39:0] exp_lanes(input frm_t f, input cfg_t c);
        logic [39:0] e;
        for (int k = 0; k < 4; k++) begin
            if (!f.data)                 e[k*10 +: 10] = TRAIN;
            else if (c.tmode && TpEn)    e[k*10 +: 10] = 10'(f.didx + k);
            else if (c.drop && f.didx == 21) e[k*10 +: 10] = '0;
            else                         e[k*10 +: 10] = 10'(f.didx + k) ^ c.dx;
        end
        return e;
    endfunction

    task automatic run_frame(input int fi, input cfg_t c);
        logic [9:0]  s;
        logic [39:0] l;
        logic        b;
        int          hs0;
        int          fd0;
        hs0       = hs_cnt;
        fd0       = fd_cnt;
        ready_idx = 0;
        drop_en   = c.drop;
        dxor      = c.dx;
        test_mode = c.tmode;
        start_frame = 1'b1;
        if (!c.skip_pre) begin
            get_word(s, l, b);
            chk($sformatf("f%0d_pre_sync", fi), 64'(s), 64'(TRAIN));
            chk($sformatf("f%0d_pre_busy", fi), 64'(b), 64'(0));
        end
        for (int i = 0; i < 80; i++) begin
            get_word(s, l, b);
            if (i == 0 && !c.hold) start_frame = 1'b0;
            if (i == 0) chk($sformatf("f%0d_urun_clr", fi), 64'(underrun), 64'(0));
            if (c.mid && i == 30) start_frame = 1'b1;
            if (c.mid && i == 31) start_frame = 1'b0;
            chk($sformatf("f%0d_w%0d_sync", fi, i), 64'(s), 64'(frm[i].sync));
            chk($sformatf("f%0d_w%0d_lanes", fi, i), 64'(l), 64'(exp_lanes(frm[i], c)));
            chk($sformatf("f%0d_w%0d_busy", fi, i), 64'(b), 64'(1));
        end
        get_word(s, l, b);
        chk($sformatf("f%0d_post_sync", fi), 64'(s), 64'(TRAIN));
        chk($sformatf("f%0d_post_lanes", fi), 64'(l), {24'h0, {4{TRAIN}}});
        chk($sformatf("f%0d_post_busy", fi), 64'(b), 64'(0));
        chk($sformatf("f%0d_done_pulses", fi), 64'(fd_cnt - fd0), 64'(1));
        chk($sformatf("f%0d_handshakes", fi), 64'(hs_cnt - hs0), 64'(c.exp_hs));
        chk($sformatf("f%0d_ready_slots", fi), 64'(ready_idx), 64'(c.exp_rdy));
        chk($sformatf("f%0d_underrun", fi), 64'(underrun), 64'(c.exp_urun));
        drop_en   = 1'b0;
        dxor      = '0;
        test_mode = 1'b0;
    endtask

    initial begin
        logic [9:0]  s;
        logic [39:0] l;
        logic        b;
        int          n;

        // Expected single-frame word sequence with default parameters.
        n = 0;
        frm[n] = '{FS, 1'b0, 0}; n++;
        for (int ln = 0; ln < 4; ln++) begin
            frm[n] = '{LS, 1'b0, 0}; n++;
            for (int w = 0; w < 16; w++) begin
                frm[n] = '{DV, 1'b1, 16 * ln + w}; n++;
            end
            frm[n] = '{LE, 1'b0, 0}; n++;
            if (ln < 3) begin
                for (int g = 0; g < 2; g++) begin
                    frm[n] = '{TRAIN, 1'b0, 0}; n++;
                end
            end
        end
        frm[n] = '{FE, 1'b0, 0};

        //          drop  hold  skip  mid   tmode dx       hs               rdy              urun
        cfg[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 64,              64,              1'b0};
        cfg[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 63,              64,              1'b1};
        cfg[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 64,              64,              1'b0};
        cfg[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 10'h000, 64,              64,              1'b0};
        cfg[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h155, TpEn ? 0 : 64,   TpEn ? 0 : 64,   1'b0};

        // Reset state.
        repeat (3) @(negedge clk_input);
        chk("rst_sync", 64'(sync_bits), 64'(0));
        chk("rst_lanes", 64'({lane3_bits, lane2_bits, lane1_bits, lane0_bits}), 64'(0));
        chk("rst_flags", 64'({busy, pix_ready, frame_done, underrun}), 64'(0));

        // Release: first clock loads TRAIN, outputs still 00.
        rst_n = 1'b1;
        @(negedge clk_input);
        chk("rel_bits", 64'({sync_bits, lane3_bits, lane2_bits, lane1_bits, lane0_bits}), 64'(0));
        for (int i = 0; i < 3; i++) begin
            get_word(s, l, b);
            chk($sformatf("idle%0d_sync", i), 64'(s), 64'(TRAIN));
            chk($sformatf("idle%0d_lanes", i), 64'(l), {24'h0, {4{TRAIN}}});
            chk($sformatf("idle%0d_busy", i), 64'(b), 64'(0));
        end

        for (int fi = 0; fi < 5; fi++) begin
            run_frame(fi, cfg[fi]);
        end

        // Reset during DATA word 7 of line 0.
        start_frame = 1'b1;
        get_word(s, l, b);
        start_frame = 1'b0;
        for (int i = 0; i < 9; i++) begin
            get_word(s, l, b);
        end
        chk("mid_pre_sync", 64'(s), 64'(DV));
        repeat (2) @(negedge clk_input);
        rst_n = 1'b0;
        @(negedge clk_input);
        chk("mid_rst_bits", 64'({sync_bits, lane3_bits, lane2_bits, lane1_bits, lane0_bits}),
            64'(0));
        chk("mid_rst_flags", 64'({busy, pix_ready, frame_done, underrun}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk_input);
        for (int i = 0; i < 2; i++) begin
            get_word(s, l, b);
            chk($sformatf("post_rst%0d_sync", i), 64'(s), 64'(TRAIN));
            chk($sformatf("post_rst%0d_lanes", i), 64'(l), {24'h0, {4{TRAIN}}});
            chk($sformatf("post_rst%0d_busy", i), 64'(b), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
